// File: rtl/chain_code_tracer_pkg.sv
// Shared constants for the chain-code tracer: FSM encodings, error codes and
// Freeman delta tables (2-bit two's complement per code, code 0 in the LSBs).
package chain_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_EMIT0 = 3'd1;
  localparam state_t ST_STEP  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERROR = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_OOB     = 2'd2;
  localparam logic [1:0] ERR_OPEN    = 2'd3;

  // codes 7..0, +1 = 01, 0 = 00, -1 = 11
  localparam logic [15:0] DX8 = 16'b01_00_11_11_11_00_01_01;
  localparam logic [15:0] DY8 = 16'b01_01_01_00_11_11_11_00;
  localparam logic [7:0]  DX4 = 8'b00_11_00_01;
  localparam logic [7:0]  DY4 = 8'b01_00_11_00;

  function automatic logic [1:0] delta_x(input logic [2:0] code, input logic conn8);
    return conn8 ? DX8[{code, 1'b0} +: 2] : DX4[{code[1:0], 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] delta_y(input logic [2:0] code, input logic conn8);
    return conn8 ? DY8[{code, 1'b0} +: 2] : DY4[{code[1:0], 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/chain_code_tracer_if.sv
// Code-in / pixel-out stream bundle of the chain-code tracer.
interface chain_code_tracer_if #(
  parameter int CW = 7,
  parameter int PW = 12
);
  logic          code_valid;
  logic [2:0]    code;
  logic          code_ready;
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [PW-1:0] pix_idx;

  modport master (
    output code_valid, code, pix_ready,
    input  code_ready, pix_valid, pix_x, pix_y, pix_idx
  );

  modport slave (
    input  code_valid, code, pix_ready,
    output code_ready, pix_valid, pix_x, pix_y, pix_idx
  );
endinterface

// File: rtl/chain_code_tracer_step.sv
// Combinational chain-code step: applies the Freeman delta to the current
// pixel and flags out-of-image results and codes illegal for 4-connectivity.
module chain_step
  import chain_pkg::*;
#(
  parameter int CW    = 7,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic [CW-1:0] cur_x,
  input  logic [CW-1:0] cur_y,
  input  logic [2:0]    code,
  input  logic          conn8,
  output logic [CW-1:0] next_x,
  output logic [CW-1:0] next_y,
  output logic          oob,
  output logic          illegal
);

  localparam logic [CW:0] LIM_X = (CW+1)'(IMG_W);
  localparam logic [CW:0] LIM_Y = (CW+1)'(IMG_H);

  logic [1:0]  dx;
  logic [1:0]  dy;
  logic [CW:0] sum_x;
  logic [CW:0] sum_y;

  // sums are CW+1-bit signed; the top bit is the sign, so an underflow or a
  // carry past 2^CW both show up as a set sign bit and are caught as oob
  always_comb begin
    dx      = delta_x(code, conn8);
    dy      = delta_y(code, conn8);
    sum_x   = {1'b0, cur_x} + {{(CW-1){dx[1]}}, dx};
    sum_y   = {1'b0, cur_y} + {{(CW-1){dy[1]}}, dy};
    illegal = !conn8 && code[2];
    oob     = sum_x[CW] || (sum_x >= LIM_X) || sum_y[CW] || (sum_y >= LIM_Y);
    next_x  = sum_x[CW-1:0];
    next_y  = sum_y[CW-1:0];
  end

endmodule

// File: rtl/chain_code_tracer.sv
// Chain-code tracer: walks a Freeman chain from a start pixel, one pixel per step.
//   state | meaning
//   IDLE  | waiting for start
//   EMIT0 | presenting the start pixel
//   STEP  | consuming codes, emitting stepped pixels
//   CHECK | closure test on final pixel
//   DONE  | trace complete, done sticky
//   ERROR | trace aborted, err_code sticky
module chain_code_tracer
  import chain_pkg::*;
#(
  parameter int CW           = 7,
  parameter int PW           = 12,
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int CHECK_CLOSED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        start_x,
  input  logic [CW-1:0]        start_y,
  input  logic [PW-1:0]        perimeter,
  input  logic                 conn8,
  chain_code_tracer_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam logic [CW:0] LIM_X = (CW+1)'(IMG_W);
  localparam logic [CW:0] LIM_Y = (CW+1)'(IMG_H);

  state_t        state;
  logic [CW-1:0] sx_q, sy_q;
  logic [PW-1:0] per_q, count_q, idx_q;
  logic          conn8_q;
  logic [CW-1:0] pix_x_q, pix_y_q;
  logic          pix_valid_q;
  logic          done_q, error_q;
  logic [1:0]    err_q;

  logic          start_oob_in, start_oob_q;
  logic          code_ready, code_hs, pix_hs;
  logic [CW-1:0] nx, ny;
  logic          step_oob, step_illegal;

  chain_step #(.CW(CW), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_step (
    .cur_x   (pix_x_q),
    .cur_y   (pix_y_q),
    .code    (bus.code),
    .conn8   (conn8_q),
    .next_x  (nx),
    .next_y  (ny),
    .oob     (step_oob),
    .illegal (step_illegal)
  );

  assign start_oob_in = ({1'b0, start_x} >= LIM_X) || ({1'b0, start_y} >= LIM_Y);
  assign start_oob_q  = ({1'b0, sx_q} >= LIM_X) || ({1'b0, sy_q} >= LIM_Y);

  // the output register can be refilled in the same cycle it is drained
  assign code_ready = (state == ST_STEP) && (count_q < per_q) &&
                      (!pix_valid_q || bus.pix_ready);
  assign code_hs    = code_ready && bus.code_valid;
  assign pix_hs     = pix_valid_q && bus.pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      sx_q        <= '0;
      sy_q        <= '0;
      per_q       <= '0;
      conn8_q     <= 1'b0;
      count_q     <= '0;
      idx_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            sx_q        <= start_x;
            sy_q        <= start_y;
            per_q       <= perimeter;
            conn8_q     <= conn8;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_q       <= ERR_NONE;
            pix_x_q     <= start_x;
            pix_y_q     <= start_y;
            idx_q       <= '0;
            count_q     <= '0;
            pix_valid_q <= !start_oob_in;
            state       <= ST_EMIT0;
          end
        end
        ST_EMIT0: begin
          if (start_oob_q) begin
            pix_valid_q <= 1'b0;
            error_q     <= 1'b1;
            err_q       <= ERR_OOB;
            state       <= ST_ERROR;
          end else if (pix_hs) begin
            pix_valid_q <= 1'b0;
            state       <= (per_q == '0) ? ST_CHECK : ST_STEP;
          end
        end
        ST_STEP: begin
          if (code_hs) begin
            if (step_illegal || step_oob) begin
              pix_valid_q <= 1'b0;
              error_q     <= 1'b1;
              err_q       <= step_illegal ? ERR_ILLEGAL : ERR_OOB;
              state       <= ST_ERROR;
            end else begin
              pix_x_q     <= nx;
              pix_y_q     <= ny;
              idx_q       <= count_q + PW'(1);
              count_q     <= count_q + PW'(1);
              pix_valid_q <= 1'b1;
            end
          end else if (pix_hs) begin
            pix_valid_q <= 1'b0;
            if (count_q == per_q) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((CHECK_CLOSED != 0) && ((pix_x_q != sx_q) || (pix_y_q != sy_q))) begin
            error_q <= 1'b1;
            err_q   <= ERR_OPEN;
            state   <= ST_ERROR;
          end else begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.code_ready = code_ready;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_idx    = idx_q;

  assign busy     = (state == ST_EMIT0) || (state == ST_STEP) || (state == ST_CHECK);
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_q;

endmodule
